// File: rtl/pool_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : pool_feeder
//  Description : Streaming BRAM reader for the 2x2 max-pool stage. It walks a
//                pixel-major feature map (8 channels per word). For every beat
//                it reads the even and the odd horizontal neighbour of one
//                pixel pair, packs the two words lane by lane, and presents
//                one beat every two cycles. The loop order is row, then pair,
//                then channel group (innermost).
//  Ports       : clk, rst (async, active high)
//                start/input_size/channel/base_addr : job request and config
//                rd_en/rd_addr/rd_data              : BRAM read port
//                infeature/feat_valid/beat_h/p/g    : pool stage input
//                busy/done                          : job status
//  Revision    : 1.0 - initial release
// ============================================================================
module pool_feeder #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [7:0]               input_size,
   input  logic [7:0]               channel,
   input  logic [ADDR_WIDTH-1:0]    base_addr,
   output logic                     rd_en,
   output logic [ADDR_WIDTH-1:0]    rd_addr,
   input  logic [DATA_WIDTH*8-1:0]  rd_data,
   output logic [DATA_WIDTH*16-1:0] infeature,
   output logic                     feat_valid,
   output logic [7:0]               beat_h,
   output logic [7:0]               beat_p,
   output logic [7:0]               beat_g,
   output logic                     busy,
   output logic                     done
);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_read  = 2'd1;
   localparam logic [1:0] c_st_drain = 2'd2;

   localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);

   // Job configuration derived from the request inputs.
   logic [7:0]            w_g_num;
   logic [7:0]            w_p_num;
   logic [7:0]            w_r_num;
   logic                  w_degen;
   logic [ADDR_WIDTH-1:0] w_gstep;
   logic [ADDR_WIDTH-1:0] w_stride;

   assign w_g_num  = (channel <= 8'd8) ? 8'd1 : {3'b000, channel[7:3]};
   assign w_p_num  = {1'b0, input_size[7:1]};
   assign w_r_num  = {input_size[7:1], 1'b0};
   assign w_degen  = (w_p_num == 8'd0) || (channel == 8'd0);
   assign w_gstep  = ADDR_WIDTH'(w_g_num);
   // Row stride in words: S pixels of G groups each, modulo the address space.
   assign w_stride = ADDR_WIDTH'(input_size) * w_gstep;

   logic [1:0]            r_state;
   logic [7:0]            r_gn;
   logic [7:0]            r_pn;
   logic [7:0]            r_rn;
   logic [ADDR_WIDTH-1:0] r_gstep;
   logic [ADDR_WIDTH-1:0] r_gstep2;
   logic [ADDR_WIDTH-1:0] r_stride;
   logic [7:0]            r_h;
   logic [7:0]            r_p;
   logic [7:0]            r_g;
   logic                  r_phase;     // 0: even read on the bus, 1: odd read
   logic [ADDR_WIDTH-1:0] r_row;       // pixel (h,0) group 0
   logic [ADDR_WIDTH-1:0] r_pair;      // pixel (h,2p) group 0
   logic [ADDR_WIDTH-1:0] r_even;      // pixel (h,2p) group g

   logic                  w_last;
   logic [ADDR_WIDTH-1:0] w_pair_next;
   logic [ADDR_WIDTH-1:0] w_row_next;

   assign w_last      = (r_h == r_rn - 8'd1) && (r_p == r_pn - 8'd1) &&
                        (r_g == r_gn - 8'd1);
   assign w_pair_next = r_pair + r_gstep2;
   assign w_row_next  = r_row + r_stride;

   // ------------------------------------------------------------------------
   // Read sequencer
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= c_st_idle;
         r_gn     <= 8'd0;
         r_pn     <= 8'd0;
         r_rn     <= 8'd0;
         r_gstep  <= '0;
         r_gstep2 <= '0;
         r_stride <= '0;
         r_h      <= 8'd0;
         r_p      <= 8'd0;
         r_g      <= 8'd0;
         r_phase  <= 1'b0;
         r_row    <= '0;
         r_pair   <= '0;
         r_even   <= '0;
         rd_en    <= 1'b0;
         rd_addr  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            c_st_idle: begin
               if (start) begin
                  if (w_degen) begin
                     done <= 1'b1;
                  end else begin
                     r_state  <= c_st_read;
                     busy     <= 1'b1;
                     r_gn     <= w_g_num;
                     r_pn     <= w_p_num;
                     r_rn     <= w_r_num;
                     r_gstep  <= w_gstep;
                     r_gstep2 <= w_gstep + w_gstep;
                     r_stride <= w_stride;
                     r_h      <= 8'd0;
                     r_p      <= 8'd0;
                     r_g      <= 8'd0;
                     r_phase  <= 1'b0;
                     r_row    <= base_addr;
                     r_pair   <= base_addr;
                     r_even   <= base_addr;
                     rd_en    <= 1'b1;
                     rd_addr  <= base_addr;
                  end
               end
            end
            c_st_read: begin
               if (!r_phase) begin
                  // Odd neighbour is one pixel (G words) after the even one.
                  r_phase <= 1'b1;
                  rd_addr <= r_even + r_gstep;
               end else begin
                  r_phase <= 1'b0;
                  if (w_last) begin
                     rd_en   <= 1'b0;
                     r_state <= c_st_drain;
                  end else if (r_g != r_gn - 8'd1) begin
                     r_g     <= r_g + 8'd1;
                     r_even  <= r_even + c_addr_one;
                     rd_addr <= r_even + c_addr_one;
                  end else if (r_p != r_pn - 8'd1) begin
                     r_g     <= 8'd0;
                     r_p     <= r_p + 8'd1;
                     r_pair  <= w_pair_next;
                     r_even  <= w_pair_next;
                     rd_addr <= w_pair_next;
                  end else begin
                     // Row advance uses the full stride so an odd last column
                     // is skipped.
                     r_g     <= 8'd0;
                     r_p     <= 8'd0;
                     r_h     <= r_h + 8'd1;
                     r_row   <= w_row_next;
                     r_pair  <= w_row_next;
                     r_even  <= w_row_next;
                     rd_addr <= w_row_next;
                  end
               end
            end
            c_st_drain: begin
               // Only the final beat can be valid once the sequencer is here.
               if (feat_valid) begin
                  r_state <= c_st_idle;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end
            default: r_state <= c_st_idle;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Return-data pipeline: tag each read with its phase and beat coordinates
   // so the data arriving one cycle later can be steered.
   // ------------------------------------------------------------------------
   logic                    r_q_valid;
   logic                    r_q_odd;
   logic [7:0]              r_q_h;
   logic [7:0]              r_q_p;
   logic [7:0]              r_q_g;
   logic [DATA_WIDTH*8-1:0] r_hold;
   logic [DATA_WIDTH*16-1:0] w_pack;

   for (genvar i = 0; i < 8; i++) begin : g_lane
      assign w_pack[DATA_WIDTH*2*i +: DATA_WIDTH]            = r_hold[DATA_WIDTH*i +: DATA_WIDTH];
      assign w_pack[DATA_WIDTH*2*i+DATA_WIDTH +: DATA_WIDTH] = rd_data[DATA_WIDTH*i +: DATA_WIDTH];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q_valid  <= 1'b0;
         r_q_odd    <= 1'b0;
         r_q_h      <= 8'd0;
         r_q_p      <= 8'd0;
         r_q_g      <= 8'd0;
         r_hold     <= '0;
         infeature  <= '0;
         feat_valid <= 1'b0;
         beat_h     <= 8'd0;
         beat_p     <= 8'd0;
         beat_g     <= 8'd0;
      end else begin
         r_q_valid  <= rd_en;
         r_q_odd    <= r_phase;
         r_q_h      <= r_h;
         r_q_p      <= r_p;
         r_q_g      <= r_g;
         feat_valid <= 1'b0;
         if (r_q_valid && !r_q_odd) begin
            r_hold <= rd_data;
         end
         if (r_q_valid && r_q_odd) begin
            infeature  <= w_pack;
            feat_valid <= 1'b1;
            beat_h     <= r_q_h;
            beat_p     <= r_q_p;
            beat_g     <= r_q_g;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/pool_feeder.md
# pool_feeder

Streaming reader that feeds the 2x2 max-pool stage. It walks a feature map stored in BRAM as pixel-major words of 8 channels. For each beat it issues two reads: the even and the odd horizontal neighbour of one pixel pair. It packs both into the pool input bus and presents one beat every 2 cycles, innermost loop over channel groups, matching the pool stage's channel-group stepping. It sits between the feature BRAM read port and the pool stage's `infeature` input.

## Interface
Parameters:
- DATA_WIDTH, 16, bits per feature value
- ADDR_WIDTH, 16, BRAM word-address width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- input_size  in  8  feature-map height = width
- channel  in  8  channel count (1..8, or a multiple of 8)
- base_addr  in  ADDR_WIDTH  BRAM word address of pixel (0,0), group 0
- rd_en  out  1  BRAM read enable
- rd_addr  out  ADDR_WIDTH  BRAM read address
- rd_data  in  DATA_WIDTH*8  BRAM read data; channel c of the group at [DATA_WIDTH*c +: DATA_WIDTH]; valid the cycle after rd_en
- infeature  out  DATA_WIDTH*16  packed pool input
- feat_valid  out  1  infeature valid this cycle
- beat_h  out  8  row of the current beat
- beat_p  out  8  pixel-pair index (covers columns 2p, 2p+1)
- beat_g  out  8  channel group of the current beat
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end

## Operation
- Configuration is latched at start acceptance and held for the whole job:
  - G = 1 if channel<=8, else channel/8.
  - S = input_size.
  - R = 2*floor(S/2) rows are read; the last row is dropped when S is odd.
  - P = floor(S/2) pairs per row; the last column is dropped when S is odd.
- Pixel (h,w), group g lives at base_addr + (h*S + w)*G + g. Addresses are computed modulo 2^ADDR_WIDTH.
- Loop order: h (outer, 0..R-1), then p (0..P-1), then g (inner, 0..G-1).
- Each beat reads pixel (h,2p) group g (the even read), then pixel (h,2p+1) group g (the odd read).
- Packing: lane i (0..7) = infeature[DATA_WIDTH*2*i +: DATA_WIDTH*2].
  - Low half of lane i = channel i of the even pixel.
  - High half of lane i = channel i of the odd pixel.
- FSM states and transitions:
  - IDLE -> READ on start, when R>0, P>0 and channel>0.
  - IDLE -> FLUSH-free DONE path: start with R=0, P=0 or channel=0 pulses done 1 cycle later, with no reads and no beats.
  - READ alternates even and odd reads every cycle with no bubbles. Counters advance after each odd read.
  - READ -> DRAIN after the last odd read.
  - DRAIN waits for the last beat to emit, then -> IDLE with a done pulse.
- start is ignored outside IDLE.
- Reset values: every output is 0 (rd_en, rd_addr, infeature, feat_valid, beat_h, beat_p, beat_g, busy, done); FSM = IDLE.
- Reset mid-job:
  - Aborts immediately: no further reads and no beats.
  - done does not pulse.
- No backpressure. The consumer must accept every beat.
- infeature and beat_h/p/g hold their last values when feat_valid=0.

## Timing
- Cycle 0 is the cycle start=1 is sampled in IDLE.
- rd_en is high continuously from cycle 1 to cycle 2N, where N = R*P*G. Odd cycles carry even reads; even cycles carry odd reads.
- Even-read data (arriving in cycle 2k) is captured into a hold register.
- Odd-read data (arriving in cycle 2k+1) is combined with the hold register and registered. feat_valid for beat k (0-based) is high in cycle 2k+4. Latency from the even read to its beat is 3 cycles.
- beat_h/p/g are registered together with infeature.
- busy is high in cycles 1..2N+2.
- done is high in cycle 2N+3 only; busy is 0 in that cycle.
- A start in cycle 2N+3 or later is accepted.
- Degenerate job: done pulses in cycle 1; busy never asserts.

## Test plan
- S=4, channel=8, base=0x100:
  - Reads 0x100..0x10F in cycles 1..16.
  - 8 beats in cycles 4,6,...,18, with (h,p) = (0,0),(0,1),(1,0)...(3,1).
  - done in cycle 19.
  - With rd_data = address replicated per lane: beat 0 lane i = {0x0101, 0x0100}.
- S=4, channel=16, base=0:
  - First reads are addresses 0, 2, 1, 3.
  - Beats 0 and 1 have g=0 and g=1 at h=0, p=0.
  - 16 beats total; done in cycle 35.
- S=5, channel=8, base=0:
  - 8 beats; row 1 even read at address 5; column 4 and row 4 never read.
  - Highest address read is 18.
- Start while busy:
  - A second start in cycle 5 of the S=4, channel=8 job is ignored; the read sequence is unchanged.
  - A start in cycle 19 (the done cycle) is accepted.
- Reset asserted asynchronously in cycle 7:
  - All outputs are 0 immediately.
  - No done pulse; no rd_en until a new start.
- Degenerate jobs:
  - S=1, channel=8: done in cycle 1, no rd_en, no feat_valid.
  - channel=0 behaves the same way.
